dmem_ctrl: RTL
==============

# dmem_ctrl

Sequencer for the data SRAM port used by the load/store path of the five-stage pipeline. It accepts one access per request from the EX side, generates the SRAM enable, byte write-enable and lane-aligned write data, waits for a variable-latency SRAM acknowledge, sign- or zero-extends load data, and returns a single-cycle response. While an access is outstanding it raises a stall request to the pipeline controller, so EX/MEM hold until the result is ready.

## Interface
- MAX_WAIT, 15: cycles spent in WAIT without `sram_ack` before the access is aborted with an error; legal range 1..255.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  access request from EX
- req_op  in  6  load/store opcode: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
- sram_en  out  1  SRAM access strobe, registered
- sram_wen  out  4  byte write enables; 0000 for loads
- sram_addr  out  32  {addr[31:2],2'b00}
- sram_wdata  out  32  lane-replicated store data
- sram_rdata  in  32  read data, valid with sram_ack
- sram_ack  in  1  one-cycle completion pulse
- resp_valid  out  1  one-cycle result pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: timeout, illegal op, or misalignment
- stallreq  out  1  to pipeline controller

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE → REQ on accept. The block latches op, addr and wdata, and computes the lane controls.
- IDLE → RESP on accept of an unrecognized op, with resp_err=1. No SRAM access is made.
- REQ: sram_en=1 for exactly one cycle. Next state is WAIT and the wait counter clears.
- WAIT:
  - On sram_ack, capture sram_rdata, extend it, and go to RESP.
  - Otherwise increment the counter. When it equals MAX_WAIT, go to RESP with resp_err=1 and resp_rdata=0.
- RESP: resp_valid=1, then IDLE.
- sram_ack is ignored in IDLE, REQ and RESP.
- Store lanes:
  - sb: wen = 0001 << addr[1:0], wdata = {4{byte}}.
  - sh: wen = addr[1] ? 1100 : 0011, wdata = {2{half}}.
  - sw: wen = 1111.
- Load extension:
  - lb/lbu take the byte at addr[1:0]; lh/lhu take the half at addr[1].
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - lw passes the full word through.
- stallreq = (state==IDLE && req_valid) || state==REQ || state==WAIT. It is low in RESP, so the pipeline advances in the cycle the result is valid.
- Reset values:
  - state IDLE and counter 0.
  - sram_en, sram_wen, sram_addr and sram_wdata are 0.
  - resp_valid, resp_rdata, resp_err and stallreq are 0.
  - req_ready is 1.
- Reset during any state returns to IDLE next cycle. An ack arriving after reset is ignored.

## Timing
- Accept in cycle 0, sram_en in cycle 1, earliest ack in cycle 2, resp_valid in cycle 3. Minimum latency is 3 cycles.
- With ack at cycle 1+k (k≥1), resp_valid arrives at cycle 2+k.
- Timeout: the counter reaches MAX_WAIT in cycle 1+MAX_WAIT, and resp_valid (err) follows in cycle 2+MAX_WAIT. An ack in the same cycle as the timeout wins: no error.
- Illegal op: resp_valid one cycle after accept.
- Back-to-back accesses: the next accept is possible in the cycle after RESP. Minimum issue interval is 4 cycles.
- req_op, req_addr and req_wdata are sampled only at accept.

## Configuration
- DMEM_MISALIGN_EXC_EN defined:
  - An lh/lhu/sh with addr[0]=1, or an lw/sw with addr[1:0]≠0, goes IDLE → RESP with resp_err=1.
  - No SRAM access is made and no write enables are asserted.
- DMEM_MISALIGN_EXC_EN undefined:
  - Misaligned low bits are ignored and the access is aligned down: lh uses addr[1] only, lw ignores addr[1:0].
  - The access proceeds normally.

## Structure
- lib/defines.vh holds the eight opcode constants, the FSM state encodings, and the DMEM request/response bus widths.
- One combinational sub-module, dmem_lane, contains the lane logic (op, addr[1:0], wdata, rdata → wen, sram_wdata, extended rdata). The FSM and counter stay in dmem_ctrl.

## Test plan
- sw addr 0x100, wdata 0xDEADBEEF, ack 1 cycle after sram_en → sram_wen=1111, sram_addr=0x100; resp_valid at cycle 3 with err=0; stallreq high in cycles 0–2.
- sb addr 0x103, wdata 0x000000A5 → sram_wen=1000, sram_wdata=0xA5A5A5A5, sram_addr=0x100.
- lb addr 0x202, rdata 0x12F03456 → resp_rdata=0xFFFFFFF0. lbu at the same address → 0x000000F0. lhu addr 0x202 → 0x000012F0.
- lw with no ack and MAX_WAIT=15 → resp_err=1, resp_rdata=0 at cycle 17. A late ack in IDLE is ignored and causes no response.
- lh addr 0x301: with DMEM_MISALIGN_EXC_EN → err at cycle 1 and sram_en never rises. Without it → reads the half at addr[1]=0.
- rst asserted in WAIT with ack in the next cycle → IDLE, req_ready=1, no resp_valid. Opcode 000000 → resp_err=1 and no sram_en.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and opcode constants for the data-SRAM sequencer.
// Build option: DMEM_MISALIGN_EXC_EN turns misaligned lh/lhu/sh/lw/sw into error responses.
package dmem_ctrl_pkg;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   localparam int DMEM_AW = 32;
   localparam int DMEM_DW = 32;

`ifdef DMEM_MISALIGN_EXC_EN
   localparam bit MISALIGN_EXC = 1'b1;
`else
   localparam bit MISALIGN_EXC = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   typedef struct packed {
      logic [3:0]         wen;
      logic [DMEM_DW-1:0] wdata;
      logic [DMEM_DW-1:0] rdata;
      logic               err;
   } lane_t;

endpackage

// File: rtl/dmem_ctrl_if.sv
// EX request / response and SRAM port bundle for dmem_ctrl.
interface dmem_ctrl_if;
   import dmem_ctrl_pkg::*;

   logic               req_valid;
   logic [5:0]         req_op;
   logic [DMEM_AW-1:0] req_addr;
   logic [DMEM_DW-1:0] req_wdata;
   logic               req_ready;
   logic               sram_en;
   logic [3:0]         sram_wen;
   logic [DMEM_AW-1:0] sram_addr;
   logic [DMEM_DW-1:0] sram_wdata;
   logic [DMEM_DW-1:0] sram_rdata;
   logic               sram_ack;
   logic               resp_valid;
   logic [DMEM_DW-1:0] resp_rdata;
   logic               resp_err;
   logic               stallreq;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, sram_rdata, sram_ack,
      output req_ready, sram_en, sram_wen, sram_addr, sram_wdata,
             resp_valid, resp_rdata, resp_err, stallreq
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, sram_rdata, sram_ack,
      input  req_ready, sram_en, sram_wen, sram_addr, sram_wdata,
             resp_valid, resp_rdata, resp_err, stallreq
   );

endinterface

// File: rtl/dmem_ctrl_lane.sv
// Combinational lane logic: store byte enables / replication, load extraction
// and extension, and the reject decision (illegal op, optional misalignment).
module dmem_lane
   import dmem_ctrl_pkg::*;
(
   input  logic [5:0]         i_op,
   input  logic [1:0]         i_addr_lo,
   input  logic [DMEM_DW-1:0] i_wdata,
   input  logic [DMEM_DW-1:0] i_rdata,
   output lane_t              o_lane
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_illegal;
   logic        w_misal;

   always_comb begin
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_lane    = '0;
      w_illegal = 1'b0;
      w_misal   = 1'b0;
      case (i_op)
         OP_LB:  o_lane.rdata = {{24{w_byte[7]}}, w_byte};
         OP_LBU: o_lane.rdata = {24'd0, w_byte};
         OP_LH: begin
            o_lane.rdata = {{16{w_half[15]}}, w_half};
            w_misal      = i_addr_lo[0];
         end
         OP_LHU: begin
            o_lane.rdata = {16'd0, w_half};
            w_misal      = i_addr_lo[0];
         end
         OP_LW: begin
            o_lane.rdata = i_rdata;
            w_misal      = |i_addr_lo;
         end
         OP_SB: begin
            o_lane.wen   = 4'b0001 << i_addr_lo;
            o_lane.wdata = {4{i_wdata[7:0]}};
         end
         OP_SH: begin
            o_lane.wen   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_lane.wdata = {2{i_wdata[15:0]}};
            w_misal      = i_addr_lo[0];
         end
         OP_SW: begin
            o_lane.wen   = 4'b1111;
            o_lane.wdata = i_wdata;
            w_misal      = |i_addr_lo;
         end
         default: w_illegal = 1'b1;
      endcase
      // Without the exception build, misaligned low bits simply align the access down.
      o_lane.err = w_illegal | (w_misal & MISALIGN_EXC);
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-SRAM access sequencer: IDLE -> REQ -> WAIT -> RESP with ack timeout.
// Build option: DMEM_MISALIGN_EXC_EN (see dmem_ctrl_pkg).
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic       clk,
   input  logic       rst,
   dmem_ctrl_if.slave bus
);

   localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

   state_t             r_state;
   logic [7:0]         r_cnt;
   logic [5:0]         r_op;
   logic [1:0]         r_alo;
   logic               r_req_ready;
   logic               r_sram_en;
   logic [3:0]         r_sram_wen;
   logic [DMEM_AW-1:0] r_sram_addr;
   logic [DMEM_DW-1:0] r_sram_wdata;
   logic               r_resp_valid;
   logic [DMEM_DW-1:0] r_resp_rdata;
   logic               r_resp_err;

   logic               w_idle;
   logic [5:0]         w_op;
   logic [1:0]         w_alo;
   logic [7:0]         w_cnt_inc;
   lane_t              w_lane;

   // Lane logic sees the live request in IDLE and the latched access afterwards.
   assign w_idle    = (r_state == S_IDLE);
   assign w_op      = w_idle ? bus.req_op : r_op;
   assign w_alo     = w_idle ? bus.req_addr[1:0] : r_alo;
   assign w_cnt_inc = r_cnt + 8'd1;

   dmem_lane u_lane (
      .i_op      (w_op),
      .i_addr_lo (w_alo),
      .i_wdata   (bus.req_wdata),
      .i_rdata   (bus.sram_rdata),
      .o_lane    (w_lane)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_op         <= '0;
         r_alo        <= '0;
         r_req_ready  <= 1'b1;
         r_sram_en    <= 1'b0;
         r_sram_wen   <= '0;
         r_sram_addr  <= '0;
         r_sram_wdata <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         r_sram_en    <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_op        <= bus.req_op;
                  r_alo       <= bus.req_addr[1:0];
                  r_req_ready <= 1'b0;
                  if (w_lane.err) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                  end else begin
                     r_state      <= S_REQ;
                     r_sram_en    <= 1'b1;
                     r_sram_wen   <= w_lane.wen;
                     r_sram_addr  <= {bus.req_addr[31:2], 2'b00};
                     r_sram_wdata <= w_lane.wdata;
                  end
               end
            end
            S_REQ: begin
               r_state    <= S_WAIT;
               r_cnt      <= '0;
               r_sram_wen <= '0;
            end
            S_WAIT: begin
               // An ack on the timeout cycle still completes the access normally.
               if (bus.sram_ack) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= w_lane.rdata;
               end else if (w_cnt_inc == MAX_W) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_RESP: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.sram_en    = r_sram_en;
   assign bus.sram_wen   = r_sram_wen;
   assign bus.sram_addr  = r_sram_addr;
   assign bus.sram_wdata = r_sram_wdata;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.resp_err   = r_resp_err;
   assign bus.stallreq   = (w_idle && bus.req_valid) || r_state == S_REQ || r_state == S_WAIT;

endmodule
